// File: rtl/spi_pkg.sv
// Shared SPI definitions: sender FSM states, default frame width and mode-0 SCLK idle level.
package spi_pkg;

    localparam int   SPI_DATA_W    = 8;
    localparam logic SPI_SCLK_IDLE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADED,
        S_SHIFT,
        S_DONE
    } sender_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK generator: divides CLK by CLK_DIV per half-period while enabled, with toggle-edge pulses.
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic CLR,
    input  logic EN,
    output logic SCLK,
    output logic RISE,
    output logic FALL
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tc;

    // RISE/FALL fire in the cycle whose closing edge performs the toggle
    assign tc   = EN && (div_cnt == DIV_LAST);
    assign RISE = tc && !SCLK;
    assign FALL = tc && SCLK;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            div_cnt <= '0;
            SCLK    <= SPI_SCLK_IDLE;
        end else if (!EN) begin
            div_cnt <= '0;
            SCLK    <= SPI_SCLK_IDLE;
        end else if (tc) begin
            div_cnt <= '0;
            SCLK    <= ~SCLK;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_sender_shifter.sv
// SPI transmit shift engine: loads a byte from the control stage and shifts it out MSB-first, mode 0.
module spi_sender_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              SENDER_WRITE,
    input  logic [DATA_W-1:0] DIN,
    input  logic              TE,
    output logic              SENDER_FULL_STATE,
    output logic              SENDER_EMPTY_STATE,
    output logic              SCLK,
    output logic              MOSI,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERRUN
);

    localparam int EC_W = $clog2(2 * DATA_W) + 1;
    localparam logic [EC_W-1:0] EDGE_LAST = EC_W'(2 * DATA_W - 1);

    sender_state_t     state, state_n;
    logic [DATA_W-1:0] shreg;
    logic [EC_W-1:0]   edge_cnt;
    logic              rise, fall;
    logic              sclk_en;
    logic              holding;

    assign sclk_en = (state == S_SHIFT);
    assign holding = (state == S_LOADED) || (state == S_SHIFT);

    spi_sclk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .CLK (CLK),
        .CLR (CLR),
        .EN  (sclk_en),
        .SCLK(SCLK),
        .RISE(rise),
        .FALL(fall)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (SENDER_WRITE) state_n = S_LOADED;
            S_LOADED: if (TE) state_n = S_SHIFT;
            S_SHIFT:  if (fall && (edge_cnt == EDGE_LAST)) state_n = S_DONE;
            S_DONE:   state_n = SENDER_WRITE ? S_LOADED : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            shreg              <= '0;
            edge_cnt           <= '0;
            SENDER_FULL_STATE  <= 1'b0;
            SENDER_EMPTY_STATE <= 1'b1;
            BUSY               <= 1'b0;
            DONE               <= 1'b0;
            OVERRUN            <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (SENDER_WRITE) shreg <= DIN;
                end
                S_LOADED: begin
                    if (TE) edge_cnt <= '0;
                end
                S_SHIFT: begin
                    if (rise || fall) edge_cnt <= edge_cnt + 1'b1;
                    if (fall) shreg <= {shreg[DATA_W-2:0], 1'b0};
                end
                default: ;
            endcase
            SENDER_FULL_STATE  <= (state_n == S_LOADED) || (state_n == S_SHIFT);
            SENDER_EMPTY_STATE <= !((state_n == S_LOADED) || (state_n == S_SHIFT));
            BUSY               <= (state_n == S_SHIFT);
            DONE               <= (state_n == S_DONE);
            OVERRUN            <= SENDER_WRITE && holding;
        end
    end

    assign MOSI = holding ? shreg[DATA_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_sender_shifter.sv
// Directed bench for spi_sender_shifter: 8-bit/CLK_DIV=2 instance plus a 16-bit/CLK_DIV=1 corner instance.
module tb_spi_sender_shifter;

    logic clk = 1'b0;
    logic clr;

    logic       write, te;
    logic [7:0] din;
    logic       full, empty, sclk, mosi, busy, done, overrun;

    logic        w16, te16;
    logic [15:0] din16;
    logic        full16, empty16, sclk16, mosi16, busy16, done16, overrun16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_sender_shifter #(.DATA_W(8), .CLK_DIV(2)) dut (
        .CLK(clk), .CLR(clr), .SENDER_WRITE(write), .DIN(din), .TE(te),
        .SENDER_FULL_STATE(full), .SENDER_EMPTY_STATE(empty), .SCLK(sclk),
        .MOSI(mosi), .BUSY(busy), .DONE(done), .OVERRUN(overrun)
    );

    spi_sender_shifter #(.DATA_W(16), .CLK_DIV(1)) dut16 (
        .CLK(clk), .CLR(clr), .SENDER_WRITE(w16), .DIN(din16), .TE(te16),
        .SENDER_FULL_STATE(full16), .SENDER_EMPTY_STATE(empty16), .SCLK(sclk16),
        .MOSI(mosi16), .BUSY(busy16), .DONE(done16), .OVERRUN(overrun16)
    );

    // Runs one 8-bit frame from LOADED (TE already high); k counts CLK edges after entry.
    task automatic cap8(input int poke_k, input bit reload, input logic [7:0] reload_d,
                        output logic [7:0] bits, output int nrise, output int rise1_k,
                        output int busy1_k, output int done_k, output int ov_cnt, output int ov_k);
        logic prev;
        prev = sclk; bits = '0; nrise = 0; rise1_k = -1; busy1_k = -1;
        done_k = -1; ov_cnt = 0; ov_k = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (!prev && sclk) begin
                bits = {bits[6:0], mosi};
                nrise++;
                if (rise1_k < 0) rise1_k = k;
            end
            prev = sclk;
            if (busy && busy1_k < 0) busy1_k = k;
            if (overrun) begin
                ov_cnt++;
                if (ov_k < 0) ov_k = k;
            end
            if (k == poke_k) begin
                write = 1'b1; din = 8'h00;
            end else if (k == poke_k + 1) begin
                write = 1'b0;
            end
            if (done) begin
                done_k = k;
                if (reload) begin
                    write = 1'b1; din = reload_d;
                end
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if ({sclk, mosi, busy, done, overrun} !== 5'b0)
            begin errors++; $display("FAIL reset_outs: got %b want 00000", {sclk, mosi, busy, done, overrun}); end
        checks++; if (empty16 !== 1'b1 || sclk16 !== 1'b0)
            begin errors++; $display("FAIL reset_16: got empty=%b sclk=%b want 1/0", empty16, sclk16); end
        clr = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] bits; int nr, r1, b1, dk, oc, ok;
        @(negedge clk);
        write = 1'b1; din = 8'hA5; te = 1'b1;
        @(negedge clk);
        write = 1'b0;
        checks++; if ({full, empty, mosi, busy} !== 4'b1010)
            begin errors++; $display("FAIL basic_loaded: got %b want 1010", {full, empty, mosi, busy}); end
        cap8(-1, 1'b0, 8'h00, bits, nr, r1, b1, dk, oc, ok);
        checks++; if (bits !== 8'hA5) begin errors++; $display("FAIL basic_bits: got %h want a5", bits); end
        checks++; if (nr !== 8)       begin errors++; $display("FAIL basic_nrise: got %0d want 8", nr); end
        checks++; if (r1 !== 3)       begin errors++; $display("FAIL basic_first_rise: got %0d want 3", r1); end
        checks++; if (dk !== 33)      begin errors++; $display("FAIL basic_done_cycle: got %0d want 33", dk); end
        checks++; if ({full, empty, sclk, busy, mosi} !== 5'b01000)
            begin errors++; $display("FAIL basic_done_outs: got %b want 01000", {full, empty, sclk, busy, mosi}); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || empty !== 1'b1)
            begin errors++; $display("FAIL basic_idle: got done=%b empty=%b want 0/1", done, empty); end
    endtask

    task automatic test_enable_gating;
        logic [7:0] bits; int nr, r1, b1, dk, oc, ok; bit held;
        te = 1'b0;
        write = 1'b1; din = 8'h3C;
        @(negedge clk);
        write = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sclk !== 1'b0 || full !== 1'b1 || busy !== 1'b0) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL gate_hold: got %b want 1", held); end
        te = 1'b1;
        cap8(-1, 1'b0, 8'h00, bits, nr, r1, b1, dk, oc, ok);
        checks++; if (b1 !== 1)       begin errors++; $display("FAIL gate_busy_start: got %0d want 1", b1); end
        checks++; if (r1 !== 3)       begin errors++; $display("FAIL gate_first_rise: got %0d want 3", r1); end
        checks++; if (bits !== 8'h3C) begin errors++; $display("FAIL gate_bits: got %h want 3c", bits); end
        @(negedge clk);
    endtask

    task automatic test_overrun;
        logic [7:0] bits; int nr, r1, b1, dk, oc, ok;
        write = 1'b1; din = 8'hFF; te = 1'b1;
        @(negedge clk);
        write = 1'b0;
        cap8(5, 1'b0, 8'h00, bits, nr, r1, b1, dk, oc, ok);
        checks++; if (oc !== 1)       begin errors++; $display("FAIL ovr_count: got %0d want 1", oc); end
        checks++; if (ok !== 6)       begin errors++; $display("FAIL ovr_cycle: got %0d want 6", ok); end
        checks++; if (bits !== 8'hFF) begin errors++; $display("FAIL ovr_bits: got %h want ff", bits); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bits; int nr, r1, b1, dk, oc, ok;
        write = 1'b1; din = 8'h66; te = 1'b1;
        @(negedge clk);
        write = 1'b0;
        cap8(-1, 1'b1, 8'h81, bits, nr, r1, b1, dk, oc, ok);
        checks++; if (bits !== 8'h66) begin errors++; $display("FAIL b2b_first_bits: got %h want 66", bits); end
        @(negedge clk);
        write = 1'b0;
        checks++; if ({full, empty, done, mosi} !== 4'b1001)
            begin errors++; $display("FAIL b2b_no_idle: got %b want 1001", {full, empty, done, mosi}); end
        cap8(-1, 1'b0, 8'h00, bits, nr, r1, b1, dk, oc, ok);
        checks++; if (bits !== 8'h81) begin errors++; $display("FAIL b2b_second_bits: got %h want 81", bits); end
        checks++; if (dk !== 33)      begin errors++; $display("FAIL b2b_done_cycle: got %0d want 33", dk); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] bits; int nr, r1, b1, dk, oc, ok; int rises; logic prev;
        write = 1'b1; din = 8'hFF; te = 1'b1;
        @(negedge clk);
        write = 1'b0;
        rises = 0; prev = sclk;
        for (int k = 0; k < 40 && rises < 3; k++) begin
            @(negedge clk);
            if (!prev && sclk) rises++;
            prev = sclk;
        end
        checks++; if (rises !== 3 || {sclk, mosi, busy} !== 3'b111)
            begin errors++; $display("FAIL rst_pre: got rises=%0d outs=%b want 3/111", rises, {sclk, mosi, busy}); end
        clr = 1'b1;
        #1;
        checks++; if ({sclk, mosi, busy, done, overrun, full, empty} !== 7'b0000001)
            begin errors++; $display("FAIL rst_async: got %b want 0000001", {sclk, mosi, busy, done, overrun, full, empty}); end
        #1;
        clr = 1'b0;
        @(negedge clk);
        write = 1'b1; din = 8'h5A;
        @(negedge clk);
        write = 1'b0;
        cap8(-1, 1'b0, 8'h00, bits, nr, r1, b1, dk, oc, ok);
        checks++; if (bits !== 8'h5A) begin errors++; $display("FAIL rst_reload_bits: got %h want 5a", bits); end
        @(negedge clk);
    endtask

    task automatic test_div1_w16;
        logic [15:0] bits; int nr, r1, bc, dk; logic prev;
        w16 = 1'b1; din16 = 16'h8001; te16 = 1'b1;
        @(negedge clk);
        w16 = 1'b0;
        bits = '0; nr = 0; r1 = -1; bc = 0; dk = -1; prev = sclk16;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (!prev && sclk16) begin
                bits = {bits[14:0], mosi16};
                nr++;
                if (r1 < 0) r1 = k;
            end
            prev = sclk16;
            if (busy16) bc++;
            if (done16) begin
                dk = k;
                break;
            end
        end
        checks++; if (bits !== 16'h8001) begin errors++; $display("FAIL w16_bits: got %h want 8001", bits); end
        checks++; if (nr !== 16)         begin errors++; $display("FAIL w16_nrise: got %0d want 16", nr); end
        checks++; if (bc !== 32)         begin errors++; $display("FAIL w16_shift_len: got %0d want 32", bc); end
        checks++; if (r1 !== 2)          begin errors++; $display("FAIL w16_first_rise: got %0d want 2", r1); end
        checks++; if (dk !== 33)         begin errors++; $display("FAIL w16_done_cycle: got %0d want 33", dk); end
        @(negedge clk);
        checks++; if (empty16 !== 1'b1 || done16 !== 1'b0)
            begin errors++; $display("FAIL w16_idle: got empty=%b done=%b want 1/0", empty16, done16); end
    endtask

    initial begin
        clr = 1'b1; write = 1'b0; te = 1'b0; din = '0;
        w16 = 1'b0; te16 = 1'b0; din16 = '0;
        test_reset();
        test_basic();
        test_enable_gating();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_div1_w16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
